// File: rtl/vscale_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit for RV32M. One request is accepted in
// IDLE, stepped XPR_LEN times, sign-corrected in FINISH, then held in DONE until
// the consumer takes it.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a request; operands latched on acceptance
//   COMPUTE | one shift-add (mul) or shift-subtract (div) step per cycle
//   FINISH  | cycle 1: conditional negate, cycle 2: select and register result
//   DONE    | resp_valid high, result held until resp_ready
module vscale_muldiv_seq #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XPR_LEN-1:0] req_in1,
  input  logic [XPR_LEN-1:0] req_in2,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_result
);

  localparam int CW = $clog2(XPR_LEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FINISH  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [XPR_LEN-1:0] b_q;
  logic [XPR_LEN-1:0] hi_q;
  logic [XPR_LEN-1:0] lo_q;
  logic [CW-1:0]      cnt_q;
  logic               fin_q;

  logic               sgn1, sgn2, neg_in, last_step, accept;
  logic [XPR_LEN-1:0] mag1, mag2;
  logic [XPR_LEN:0]   mul_sum;
  logic [XPR_LEN:0]   div_r;
  logic               div_ge;
  logic [XPR_LEN-1:0] rem_next;
  logic [2*XPR_LEN-1:0] prod_neg;

  // Request decode: operand magnitudes and the sign of the final result.
  always_comb begin
    sgn1   = 1'b0;
    sgn2   = 1'b0;
    neg_in = 1'b0;
    if (req_op == OP_MULH || req_op == OP_MULHSU || req_op == OP_DIV || req_op == OP_REM)
      sgn1 = req_in1[XPR_LEN-1];
    if (req_op == OP_MULH || req_op == OP_DIV || req_op == OP_REM)
      sgn2 = req_in2[XPR_LEN-1];
    mag1 = sgn1 ? -req_in1 : req_in1;
    mag2 = sgn2 ? -req_in2 : req_in2;
    if (!req_op[2])
      neg_in = sgn1 ^ sgn2;
    else if (req_op == OP_DIV)
      neg_in = (req_in2 == '0) ? 1'b0 : (sgn1 ^ sgn2);
    else if (req_op == OP_REM)
      neg_in = sgn1;
  end

  // One iteration of the multiplier (shift-add) and divider (restoring subtract).
  // A zero divisor always "fits", giving an all-ones quotient and the dividend
  // shifted intact into the remainder.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_r    = {hi_q, lo_q[XPR_LEN-1]};
    div_ge   = div_r >= {1'b0, b_q};
    rem_next = div_ge ? (div_r[XPR_LEN-1:0] - b_q) : div_r[XPR_LEN-1:0];
    prod_neg = -{hi_q, lo_q};
  end

  assign last_step = (cnt_q == CW'(XPR_LEN - 1));
  assign accept    = req_valid && !kill;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (kill)           state_d = IDLE;
        else if (last_step) state_d = FINISH;
      end
      FINISH: begin
        if (kill)       state_d = IDLE;
        else if (fin_q) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (kill || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, sign correction and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      resp_result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            neg_q <= neg_in;
            b_q   <= mag2;
            hi_q  <= '0;
            lo_q  <= mag1;
            cnt_q <= '0;
            fin_q <= 1'b0;
          end
        end
        COMPUTE: begin
          cnt_q <= cnt_q + CW'(1);
          if (!op_q[2]) begin
            hi_q <= mul_sum[XPR_LEN:1];
            lo_q <= {mul_sum[0], lo_q[XPR_LEN-1:1]};
          end else begin
            hi_q <= rem_next;
            lo_q <= {lo_q[XPR_LEN-2:0], div_ge};
          end
        end
        FINISH: begin
          if (!fin_q) begin
            fin_q <= 1'b1;
            if (neg_q) begin
              if (!op_q[2]) begin
                hi_q <= prod_neg[2*XPR_LEN-1:XPR_LEN];
                lo_q <= prod_neg[XPR_LEN-1:0];
              end else begin
                hi_q <= -hi_q;
                lo_q <= -lo_q;
              end
            end
          end else begin
            resp_result <= (op_q == OP_MUL || op_q == OP_DIV || op_q == OP_DIVU) ? lo_q : hi_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
